// File: rtl/cs_subtractor_seq.sv
// Sequential carry-select subtractor: resolves one SLICE-bit slice per clock, low slice first.
// Optional `define CS_SUB_ADD_EN adds an op_add port selecting a + b + bin instead of a - b - bin.
module cs_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef CS_SUB_ADD_EN
  input  logic             op_add,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic             carry_q, carry_d;
  logic             add_q, add_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   sum0, sum1, sel;
  logic             last_slice;

  // Both carry-in candidates are formed every cycle; the running carry picks one.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSL; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = bx_q[i*SLICE +: SLICE];
      end
    end
    sum0       = {1'b0, a_sl} + {1'b0, b_sl};
    sum1       = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(1);
    sel        = carry_q ? sum1 : sum0;
    last_slice = (idx_q == IDXW'(NSL - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    bx_d    = bx_q;
    carry_d = carry_q;
    add_d   = add_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          bx_d    = ~b;
          carry_d = ~bin;
          add_d   = 1'b0;
`ifdef CS_SUB_ADD_EN
          if (op_add) begin
            bx_d    = b;
            carry_d = bin;
            add_d   = 1'b1;
          end
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSL; i++) begin
          if (idx_q == IDXW'(i)) diff_d[i*SLICE +: SLICE] = sel[SLICE-1:0];
        end
        carry_d = sel[SLICE];
        idx_d   = idx_q + IDXW'(1);
        if (last_slice) begin
          // bx_q already holds ~b for subtract, so one sign-compare covers both modes.
          bout_d  = add_q ? sel[SLICE] : ~sel[SLICE];
          ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      bx_q    <= '0;
      carry_q <= 1'b0;
      add_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      carry_q <= carry_d;
      add_q   <= add_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cs_subtractor_seq.sv
// Directed bench for cs_subtractor_seq: vector table plus backpressure and mid-run reset sequences.
module tb_cs_subtractor_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
`ifdef CS_SUB_ADD_EN
  logic         op_add;
`endif

  int checks   = 0;
  int failures = 0;

  cs_subtractor_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
`ifdef CS_SUB_ADD_EN
    .op_add    (op_add),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one cycle; the accept edge is the posedge inside this task.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
    a        = va;
    b        = vb;
    bin      = vbin;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) chk({name, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      if (out_valid) break;
      step();
      k = i;
    end
    chk({name, "_latency"}, 32'(k), 32'd4);
    if (!out_valid) begin
      $display("FAIL %s_timeout: out_valid never rose", name);
      failures++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    start_op(v.a, v.b, v.bin);
    chk({name, "_accept_in_ready"}, 32'(in_ready), 32'd0);
    wait_done(name);
    chk({name, "_diff"}, 32'(diff), 32'(v.diff));
    chk({name, "_bout"}, 32'(bout), 32'(v.bout));
    chk({name, "_ovf"},  32'(ovf),  32'(v.ovf));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_release_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
`ifdef CS_SUB_ADD_EN
    op_add    = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff",      32'(diff),      32'd0);
    chk("rst_bout",      32'(bout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_out_ready_ignored", 32'(out_valid), 32'd0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result must hold while a stray in_valid is presented.
    start_op(16'h1234, 16'h0234, 1'b0);
    wait_done("bp");
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        a        = 16'hFFFF;
        b        = 16'h0000;
        bin      = 1'b1;
        in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      chk($sformatf("bp_hold%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_in_ready", c),  32'(in_ready),  32'd0);
      chk($sformatf("bp_hold%0d_diff", c),      32'(diff),      32'h1000);
      chk($sformatf("bp_hold%0d_bout", c),      32'(bout),      32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_in_ready",  32'(in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    step();
    chk("bp_stray_not_started", 32'(in_ready), 32'd1);

    // Reset while slice 2 is the one being resolved; slices 0-1 already wrote 0xFF.
    start_op(16'h0000, 16'h0001, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_diff",      32'(diff),      32'd0);
    chk("midrst_bout",      32'(bout),      32'd0);
    repeat (6) step();
    chk("midrst_stays_idle", 32'(out_valid), 32'd0);
    run_vec("post_rst", vecs[2]);

`ifdef CS_SUB_ADD_EN
    op_add = 1'b1;
    run_vec("add", '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
    run_vec("add_ovf", '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
    op_add = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
